// File: rtl/calc_operand_sequencer_if.sv
// Operand-sequencer bus: switch/button inputs and ALU-facing outputs.
// The ALU side and board side share one bundle; clk/reset stay separate.
interface calc_operand_sequencer_if #(
   parameter int in_length = 16
);
   logic [in_length-1:0] data_in;
   logic                 enter;
   logic                 undo;
   logic [in_length-1:0] result_in;
   logic [2:0]           error_in;
   logic [in_length-1:0] A;
   logic [in_length-1:0] B;
   logic [in_length-1:0] OP;
   logic [1:0]           stage;
   logic                 load_done;
   logic [in_length-1:0] display_value;
   logic [2:0]           error_led;

   modport master (
      output data_in, enter, undo,
      output result_in, error_in,
      input  A, B, OP, stage, load_done,
      input  display_value, error_led
   );

   modport slave (
      input  data_in, enter, undo,
      input  result_in, error_in,
      output A, B, OP, stage, load_done,
      output display_value, error_led
   );
endinterface

// File: rtl/calc_operand_sequencer.sv
// Calculator front end: captures A, B and opcode on Enter, steps back
// on Undo, and muxes the 7-segment display between entry and result.
module calc_operand_sequencer #(
   parameter int in_length = 16
) (
   input logic                     clk,
   input logic                     reset,
   calc_operand_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_OP  = 2'd2,
      S_RES = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [in_length-1:0] a_q, a_d;
   logic [in_length-1:0] b_q, b_d;
   logic [in_length-1:0] op_q, op_d;
   logic                 load_done_q, load_done_d;
   logic                 enter_q, undo_q;
   logic                 enter_rise, undo_rise;

   assign enter_rise = bus.enter & ~enter_q;
   assign undo_rise  = bus.undo & ~undo_q;

   // Enter is checked first in every state so it wins over a same-cycle Undo.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      load_done_d = 1'b0;
      unique case (state_q)
         S_A: begin
            if (enter_rise) begin
               a_d     = bus.data_in;
               state_d = S_B;
            end
         end
         S_B: begin
            if (enter_rise) begin
               b_d     = bus.data_in;
               state_d = S_OP;
            end else if (undo_rise) begin
               state_d = S_A;
            end
         end
         S_OP: begin
            if (enter_rise) begin
               op_d        = {{(in_length-2){1'b0}}, bus.data_in[1:0]};
               load_done_d = 1'b1;
               state_d     = S_RES;
            end else if (undo_rise) begin
               state_d = S_B;
            end
         end
         S_RES: begin
            if (enter_rise) begin
               state_d = S_A;
            end else if (undo_rise) begin
               state_d = S_OP;
            end
         end
         default: state_d = S_A;
      endcase
   end

   // Button history resets high so a press held through reset is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_A;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         load_done_q <= 1'b0;
         enter_q     <= 1'b1;
         undo_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         load_done_q <= load_done_d;
         enter_q     <= bus.enter;
         undo_q      <= bus.undo;
      end
   end

   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.OP        = op_q;
   assign bus.stage     = state_q;
   assign bus.load_done = load_done_q;

   always_comb begin
      bus.display_value = bus.data_in;
      bus.error_led     = 3'b000;
      if (state_q == S_RES) begin
         bus.display_value = bus.result_in;
         bus.error_led     = bus.error_in;
      end
   end
endmodule
